bip_control: RTL and testbench
==============================

# bip_control

Instruction sequencer for the BIP accumulator processor. It holds the program counter, fetches 16-bit instructions from program memory, and decodes each one into the datapath's select, write-enable and add/sub controls. It also drives the data-memory read/write strobes. It sits between program memory, the accumulator datapath and data memory, and provides a start/halt handshake plus a cycle counter to the top level.

## Interface
- PC_WIDTH, 11, program-counter and operand width
- OPCODE_WIDTH, 5, opcode field width (instruction bits [15:11])
- INSTR_WIDTH, 16, instruction word width
- CNT_WIDTH, 16, cycle-counter width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- i_start  in  1  level; sampled in IDLE to begin execution
- i_instruction  in  16  program-memory read data for o_pc (asynchronous read)
- o_pc  out  11  program-memory address
- o_operand  out  11  i_instruction[10:0], passed to the datapath
- o_sel_a  out  2  accumulator source: 0 = data memory, 1 = sign-extended operand, 2 = ALU result
- o_sel_b  out  1  ALU B input: 0 = data memory, 1 = operand
- o_write_acc  out  1  accumulator write enable
- o_operation  out  1  0 = add, 1 = subtract
- o_wr_ram  out  1  data-memory write strobe
- o_rd_ram  out  1  data-memory read strobe
- o_halted  out  1  high while in HALT
- o_cycle_count  out  16  number of RUN cycles executed

## Operation
- States: IDLE, RUN, HALT. Reset state is IDLE.
- Transitions:
  - IDLE -> RUN when i_start = 1.
  - RUN -> HALT when the decoded opcode is HLT.
  - HALT persists until reset.
  - i_start is ignored outside IDLE.
- Decode is combinational from i_instruction and is active only in RUN.
- In IDLE and HALT all control outputs are 0: sel_a = 0, sel_b = 0, write_acc = 0, operation = 0, wr_ram = 0, rd_ram = 0.
- Opcodes (5 bits) and their outputs (write_acc / sel_a / sel_b / operation / rd / wr):
  - HLT 00000: all 0; PC holds.
  - STO 00001: wr_ram = 1 only.
  - LD 00010: 1 / 0 / x / 0 / 1 / 0.
  - LDI 00011: 1 / 1 / x / 0 / 0 / 0.
  - ADD 00100: 1 / 2 / 0 / 0 / 1 / 0.
  - ADDI 00101: 1 / 2 / 1 / 0 / 0 / 0.
  - SUB 00110: 1 / 2 / 0 / 1 / 1 / 0.
  - SUBI 00111: 1 / 2 / 1 / 1 / 0 / 0.
  - "x" is driven as 0.
- Any other opcode is a NOP: all controls 0 and the PC advances.
- PC:
  - Increments by 1 on each posedge in RUN when the opcode is not HLT.
  - Modulo 2^PC_WIDTH: 2047 -> 0, no flag.
  - Holds in IDLE and HALT.
- Cycle counter:
  - Increments on each posedge while in RUN, including the HLT cycle.
  - Saturates at 0xFFFF.
  - Holds in IDLE and HALT.
- o_operand = i_instruction[10:0] in every state.

## Timing
- Reset (rst = 0 at posedge): o_pc = 0, state = IDLE, o_cycle_count = 0, o_halted = 0, all control strobes 0.
- Reset mid-RUN has the same effect; execution restarts only after a new i_start.
- Start handshake: i_start high at posedge N moves the block to RUN. The instruction at PC 0 is decoded during cycle N+1.
- Single-cycle execution, one instruction per clock:
  - Controls are valid combinationally shortly after o_pc changes.
  - The datapath latches the accumulator on the negedge of the same cycle.
  - Data memory writes on the following posedge while o_wr_ram = 1.
  - The PC advances on that same posedge.
- HLT: the posedge that decodes HLT moves the state to HALT. o_halted rises after that edge; o_pc stays at the HLT address.
- The state never returns to IDLE without reset.

## Test plan
- Reset, then start; program LDI 5, ADDI 3, STO 10, HLT -> mem[10] = 8, o_pc = 3 in HALT, o_cycle_count = 4, o_halted = 1.
- Program LD 10 (mem[10] = 20), SUBI 25, SUB 10 -> accumulator -5, then -25. Check o_operation = 1 and o_sel_b = 0/1 on the respective cycles.
- Opcode 11111 at PC 0, then HLT -> no strobes on the first cycle, PC advances to 1, then halts.
- Preload o_pc near 2047 (a run of NOPs) -> PC wraps to 0 and continues without stalling.
- Assert rst = 0 mid-RUN -> next cycle o_pc = 0, IDLE, count = 0, strobes 0. Then hold i_start low for 5 cycles -> PC and count stay 0.
- Pulse i_start in HALT -> no change. Run over 65535 RUN cycles -> o_cycle_count stays at 0xFFFF.

Source files
------------

// File: rtl/bip_control.sv
// BIP instruction sequencer: program counter, single-cycle decode into datapath
// and data-memory controls, start/halt handshake and saturating RUN-cycle counter.
module bip_control #(
   parameter int PC_WIDTH     = 11,
   parameter int OPCODE_WIDTH = 5,
   parameter int INSTR_WIDTH  = 16,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [INSTR_WIDTH-1:0] i_instruction,
   output logic [PC_WIDTH-1:0]    o_pc,
   output logic [PC_WIDTH-1:0]    o_operand,
   output logic [1:0]             o_sel_a,
   output logic                   o_sel_b,
   output logic                   o_write_acc,
   output logic                   o_operation,
   output logic                   o_wr_ram,
   output logic                   o_rd_ram,
   output logic                   o_halted,
   output logic [CNT_WIDTH-1:0]   o_cycle_count,
   output logic [1:0]             o_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
   localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
   localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t                state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [OPCODE_WIDTH-1:0] opcode;

   assign opcode        = i_instruction[INSTR_WIDTH-1:INSTR_WIDTH-OPCODE_WIDTH];
   assign o_operand     = i_instruction[PC_WIDTH-1:0];
   assign o_pc          = pc_q;
   assign o_cycle_count = cnt_q;
   assign o_halted      = (state_q == ST_HALT);
   assign o_state       = state_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      o_sel_a     = 2'd0;
      o_sel_b     = 1'b0;
      o_write_acc = 1'b0;
      o_operation = 1'b0;
      o_wr_ram    = 1'b0;
      o_rd_ram    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) state_d = ST_RUN;
         end
         ST_RUN: begin
            // The HLT cycle itself is counted; the PC stays on the HLT address.
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (opcode == OP_HLT) begin
               state_d = ST_HALT;
            end else begin
               pc_d = pc_q + 1'b1;
            end
            case (opcode)
               OP_STO: o_wr_ram = 1'b1;
               OP_LD: begin
                  o_write_acc = 1'b1;
                  o_rd_ram    = 1'b1;
               end
               OP_LDI: begin
                  o_write_acc = 1'b1;
                  o_sel_a     = 2'd1;
               end
               OP_ADD: begin
                  o_write_acc = 1'b1;
                  o_sel_a     = 2'd2;
                  o_rd_ram    = 1'b1;
               end
               OP_ADDI: begin
                  o_write_acc = 1'b1;
                  o_sel_a     = 2'd2;
                  o_sel_b     = 1'b1;
               end
               OP_SUB: begin
                  o_write_acc = 1'b1;
                  o_sel_a     = 2'd2;
                  o_operation = 1'b1;
                  o_rd_ram    = 1'b1;
               end
               OP_SUBI: begin
                  o_write_acc = 1'b1;
                  o_sel_a     = 2'd2;
                  o_sel_b     = 1'b1;
                  o_operation = 1'b1;
               end
               default: ;
            endcase
         end
         ST_HALT: ;
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: program/data memories and an accumulator model around the
// sequencer; per-cycle control words are checked against an expected queue.
module tb_bip_control;

   localparam int W = 19;

   // Handshake: the sequencer has no valid/ready pair; while arm is high the monitor
   // treats every negedge as one presented control word and pops one expectation.
   logic        clk;
   logic        rst;
   logic        i_start;
   logic [15:0] i_instruction;
   logic [10:0] o_pc;
   logic [10:0] o_operand;
   logic [1:0]  o_sel_a;
   logic        o_sel_b;
   logic        o_write_acc;
   logic        o_operation;
   logic        o_wr_ram;
   logic        o_rd_ram;
   logic        o_halted;
   logic [15:0] o_cycle_count;
   logic [1:0]  o_state;

   logic [15:0] prog [0:2047];
   logic [15:0] dmem [0:2047];
   logic [15:0] acc;
   logic [15:0] acc_log[$];
   logic [W-1:0] exp_q[$];
   logic        arm;
   int          checks;
   int          errors;

   bip_control dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_instruction(i_instruction),
      .o_pc(o_pc), .o_operand(o_operand), .o_sel_a(o_sel_a), .o_sel_b(o_sel_b),
      .o_write_acc(o_write_acc), .o_operation(o_operation), .o_wr_ram(o_wr_ram),
      .o_rd_ram(o_rd_ram), .o_halted(o_halted), .o_cycle_count(o_cycle_count),
      .o_state(o_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign i_instruction = prog[o_pc];

   // ---------------- datapath and data-memory model ----------------
   always @(negedge clk) begin
      logic [15:0] opd, b, nv;
      opd = {{5{o_operand[10]}}, o_operand};
      b   = o_sel_b ? opd : dmem[o_operand];
      if (o_write_acc) begin
         case (o_sel_a)
            2'd0:    nv = dmem[o_operand];
            2'd1:    nv = opd;
            default: nv = o_operation ? acc - b : acc + b;
         endcase
         acc = nv;
         acc_log.push_back(nv);
      end
   end

   always @(posedge clk) begin
      if (o_wr_ram) dmem[o_operand] <= acc;
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [W-1:0] e, a;
      forever begin
         @(negedge clk);
         if (arm && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {o_pc, o_halted, o_write_acc, o_sel_a, o_sel_b, o_operation, o_rd_ram, o_wr_ram};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL ctrl_word pc/halt/wa/sa/sb/op/rd/wr actual %h required %h", a, e);
            end
         end
      end
   end

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] opd);
      return {opc, opd};
   endfunction

   function automatic logic [W-1:0] ev(input logic [10:0] pc, input logic h, input logic wa,
                                       input logic [1:0] sa, input logic sb, input logic op,
                                       input logic rd, input logic wr);
      return {pc, h, wa, sa, sb, op, rd, wr};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic fill(input logic [15:0] w);
      for (int i = 0; i < 2048; i++) prog[i] = w;
   endtask

   task automatic start_run(input logic do_arm);
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      arm = do_arm;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({name, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
      arm = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks  = 0;
      errors  = 0;
      arm     = 1'b0;
      i_start = 1'b0;
      acc     = 16'h0;
      for (int i = 0; i < 2048; i++) dmem[i] = 16'h0;
      fill(ins(5'b11111, 11'd0));

      // reset state
      do_reset();
      chk("rst_pc", o_pc, 0);
      chk("rst_count", o_cycle_count, 0);
      chk("rst_halted", o_halted, 0);
      chk("rst_strobes", {o_write_acc, o_sel_a, o_sel_b, o_operation, o_rd_ram, o_wr_ram}, 0);

      // LDI 5, ADDI 3, STO 10, HLT
      prog[0] = ins(5'b00011, 11'd5);
      prog[1] = ins(5'b00101, 11'd3);
      prog[2] = ins(5'b00001, 11'd10);
      prog[3] = ins(5'b00000, 11'd0);
      exp_q.push_back(ev(11'd0, 0, 1, 2'd1, 0, 0, 0, 0));
      exp_q.push_back(ev(11'd1, 0, 1, 2'd2, 1, 0, 0, 0));
      exp_q.push_back(ev(11'd2, 0, 0, 2'd0, 0, 0, 0, 1));
      exp_q.push_back(ev(11'd3, 0, 0, 2'd0, 0, 0, 0, 0));
      exp_q.push_back(ev(11'd3, 1, 0, 2'd0, 0, 0, 0, 0));
      start_run(1'b1);
      drain("prog1");
      chk("prog1_mem10", dmem[10], 16'd8);
      chk("prog1_pc", o_pc, 3);
      chk("prog1_count", o_cycle_count, 4);
      chk("prog1_halted", o_halted, 1);

      // i_start pulsed in HALT is ignored
      start_run(1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("halt_start_pc", o_pc, 3);
      chk("halt_start_count", o_cycle_count, 4);
      chk("halt_start_halted", o_halted, 1);

      // LD 10, SUBI 25, SUB 10, HLT with mem[10] = 20
      do_reset();
      dmem[10] = 16'd20;
      acc_log.delete();
      prog[0] = ins(5'b00010, 11'd10);
      prog[1] = ins(5'b00111, 11'd25);
      prog[2] = ins(5'b00110, 11'd10);
      prog[3] = ins(5'b00000, 11'd0);
      exp_q.push_back(ev(11'd0, 0, 1, 2'd0, 0, 0, 1, 0));
      exp_q.push_back(ev(11'd1, 0, 1, 2'd2, 1, 1, 0, 0));
      exp_q.push_back(ev(11'd2, 0, 1, 2'd2, 0, 1, 1, 0));
      exp_q.push_back(ev(11'd3, 0, 0, 2'd0, 0, 0, 0, 0));
      exp_q.push_back(ev(11'd3, 1, 0, 2'd0, 0, 0, 0, 0));
      start_run(1'b1);
      drain("prog2");
      chk("prog2_acc_writes", acc_log.size(), 3);
      if (acc_log.size() == 3) begin
         chk("prog2_acc_ld", acc_log[0], 16'd20);
         chk("prog2_acc_subi", acc_log[1], 16'hFFFB);
         chk("prog2_acc_sub", acc_log[2], 16'hFFE7);
      end

      // unknown opcode is a NOP, then HLT
      do_reset();
      prog[0] = ins(5'b11111, 11'h7FF);
      prog[1] = ins(5'b00000, 11'd0);
      exp_q.push_back(ev(11'd0, 0, 0, 2'd0, 0, 0, 0, 0));
      exp_q.push_back(ev(11'd1, 0, 0, 2'd0, 0, 0, 0, 0));
      exp_q.push_back(ev(11'd1, 1, 0, 2'd0, 0, 0, 0, 0));
      start_run(1'b1);
      drain("nop");
      chk("nop_pc", o_pc, 1);
      chk("nop_count", o_cycle_count, 2);

      // PC wrap 2047 -> 0 through a run of NOPs
      do_reset();
      fill(ins(5'b11111, 11'd0));
      start_run(1'b0);
      begin
         int n;
         n = 0;
         while (o_pc != 11'd2047 && n < 3000) begin
            @(negedge clk);
            n++;
         end
         chk("wrap_reached_2047", o_pc, 11'd2047);
      end
      #1;
      prog[1] = ins(5'b00000, 11'd0);
      exp_q.push_back(ev(11'd0, 0, 0, 2'd0, 0, 0, 0, 0));
      exp_q.push_back(ev(11'd1, 0, 0, 2'd0, 0, 0, 0, 0));
      exp_q.push_back(ev(11'd1, 1, 0, 2'd0, 0, 0, 0, 0));
      arm = 1'b1;
      drain("wrap");
      chk("wrap_count", o_cycle_count, 2050);

      // reset mid-RUN, then no restart without i_start
      do_reset();
      fill(ins(5'b00011, 11'd1));
      start_run(1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("midrun_running", o_write_acc, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrun_pc", o_pc, 0);
      chk("midrun_count", o_cycle_count, 0);
      chk("midrun_halted", o_halted, 0);
      chk("midrun_strobes", {o_write_acc, o_sel_a, o_sel_b, o_operation, o_rd_ram, o_wr_ram}, 0);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_pc", o_pc, 0);
      chk("idle_count", o_cycle_count, 0);
      chk("idle_strobes", o_write_acc, 0);

      // cycle counter saturates at 0xFFFF
      do_reset();
      fill(ins(5'b11111, 11'd0));
      start_run(1'b0);
      begin
         int n;
         n = 0;
         while (o_cycle_count != 16'hFFFF && n < 70000) begin
            @(posedge clk);
            n++;
         end
      end
      repeat (10) @(posedge clk);
      #1;
      chk("sat_count", o_cycle_count, 16'hFFFF);
      chk("sat_not_halted", o_halted, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
